// File: rtl/quad_enc_decoder_pkg.sv
// Shared types and helpers for the quadrature encoder decoder.
package quad_enc_decoder_pkg;

    // Encodings follow the CW order, so a CW step is +1 and a CCW step is -1 (mod 4).
    typedef enum logic [1:0] {
        S00 = 2'd0,
        S01 = 2'd1,
        S11 = 2'd2,
        S10 = 2'd3
    } qstate_t;

    localparam logic DIR_CW  = 1'b0;
    localparam logic DIR_CCW = 1'b1;

    // Map the filtered {b,a} pair onto its state (Gray to binary).
    function automatic qstate_t ab_to_state(input logic b, input logic a);
        return qstate_t'({b, b ^ a});
    endfunction

endpackage

// File: rtl/quad_enc_decoder_sync_filter.sv
// One encoder channel: metastability synchronizer followed by a stability filter.
module quad_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          stable_cnt;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

    // Accept a new level only after it differs from the current one for FILT_LEN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (synced == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt == LAST) begin
            stable_cnt <= '0;
            level      <= synced;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_enc_decoder.sv
// Quadrature encoder front end: sync/filter per channel, x4 decode, position counter.
module quad_enc_decoder
    import quad_enc_decoder_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int FILT_LEN    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    // Init window: long enough for a level present at reset release to reach the
    // decoder. If no filtered change shows up by then, the idle level is taken as
    // the starting state, so the first real edge from an idle start is counted.
    localparam int SETTLE = SYNC_STAGES + FILT_LEN + 2;
    localparam int SW     = $clog2(SETTLE + 1);

    logic [1:0]    rst_pipe;
    logic          rst_i;
    logic          fa, fb;
    qstate_t       cur, state;
    logic [1:0]    cur_idx, st_idx, delta;
    logic          init;
    logic [SW-1:0] settle_cnt;
    logic          moved, cw, ccw, bad;

    // Assert reset asynchronously, release it synchronously to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_pipe <= 2'b11;
        else     rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign rst_i = rst_pipe[1];

    quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .rst(rst_i), .raw(a), .level(fa)
    );
    quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .rst(rst_i), .raw(b), .level(fb)
    );

    assign cur     = ab_to_state(fb, fa);
    assign cur_idx = cur;
    assign st_idx  = state;
    assign delta   = cur_idx - st_idx;
    assign moved   = !init && (cur != state);
    assign cw      = moved && (delta == 2'd1);
    assign ccw     = moved && (delta == 2'd3);
    assign bad     = moved && (delta == 2'd2);

    // Decoder FSM with registered direction, step/err pulses and position counter.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state      <= S00;
            init       <= 1'b1;
            settle_cnt <= '0;
            count      <= '0;
            dir        <= DIR_CW;
            step       <= 1'b0;
            err        <= 1'b0;
        end else begin
            step <= cw | ccw;
            err  <= bad;
            if (init) begin
                settle_cnt <= settle_cnt + 1'b1;
                if (cur != state) begin
                    state <= cur;
                    init  <= 1'b0;
                end else if (settle_cnt == SW'(SETTLE)) begin
                    init  <= 1'b0;
                end
            end else if (cur != state) begin
                state <= cur;
            end
            if (cw)  dir <= DIR_CW;
            if (ccw) dir <= DIR_CCW;
            if (clr)      count <= '0;
            else if (cw)  count <= count + 1'b1;
            else if (ccw) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Directed bench for quad_enc_decoder with a pulse scoreboard.
module tb_quad_enc_decoder;

    typedef struct {
        logic        step;
        logic        err;
        logic [15:0] count;
        logic        dir;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a = 1'b0, b = 1'b0, clr = 1'b0;
    logic [15:0] count;
    logic        dir, step, err;
    logic [7:0]  count8;
    logic        dir8, step8, err8;

    int errors = 0;
    int checks = 0;
    int step_cnt = 0;
    int err_cnt = 0;

    ev_t         sb[$];
    logic [1:0]  model_ab = 2'b00;
    logic [15:0] model_count = 16'h0;
    logic        model_dir = 1'b0;
    logic [1:0]  cw_seq[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    quad_enc_decoder dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .count(count), .dir(dir), .step(step), .err(err)
    );

    quad_enc_decoder #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .count(count8), .dir(dir8), .step(step8), .err(err8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: position in the CW sequence decides the step kind.
    task automatic model_move(input logic [1:0] nab);
        ev_t e;
        int  pos = 0;
        if (nab == model_ab) return;
        for (int i = 0; i < 4; i++) if (cw_seq[i] == model_ab) pos = i;
        e.step = 1'b0; e.err = 1'b0;
        if (nab == cw_seq[(pos + 1) % 4]) begin
            model_count = model_count + 16'd1; model_dir = 1'b0; e.step = 1'b1;
        end else if (nab == cw_seq[(pos + 3) % 4]) begin
            model_count = model_count - 16'd1; model_dir = 1'b1; e.step = 1'b1;
        end else begin
            e.err = 1'b1;
        end
        e.count = model_count;
        e.dir   = model_dir;
        model_ab = nab;
        sb.push_back(e);
    endtask

    // Drive {b,a} so it is sampled by exactly n rising edges before the next change.
    task automatic set_ab(input logic [1:0] nab, input int n);
        @(posedge clk); #1;
        {b, a} = nab;
        model_move(nab);
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic cycle(input logic ccw, input int n);
        for (int k = 1; k <= 4; k++) set_ab(ccw ? cw_seq[(4 - k) % 4] : cw_seq[k % 4], n);
    endtask

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && (step === 1'b1 || err === 1'b1)) begin
            if (step === 1'b1) step_cnt++;
            if (err === 1'b1) err_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'({step, err}), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("sb_step", 32'(step), 32'(e.step));
                chk("sb_err", 32'(err), 32'(e.err));
                chk("sb_count", 32'(count), 32'(e.count));
                chk("sb_dir", 32'(dir), 32'(e.dir));
            end
        end
    end

    initial begin
        int s0;
        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(negedge clk); rst = 1'b0;
        repeat (30) @(posedge clk);

        // 1: three CW cycles from reset
        repeat (3) cycle(1'b0, 25);
        repeat (20) @(posedge clk); #1;
        chk("t1_count", 32'(count), 32'd12);
        chk("t1_dir", 32'(dir), 32'h0);
        chk("t1_steps", 32'(step_cnt), 32'd12);
        chk("t1_errs", 32'(err_cnt), 32'd0);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: five CCW cycles
        repeat (5) cycle(1'b1, 25);
        repeat (20) @(posedge clk); #1;
        chk("t2_count", 32'(count), 32'h0000FFF8);
        chk("t2_dir", 32'(dir), 32'h1);
        chk("t2_steps", 32'(step_cnt), 32'd32);
        chk("t2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: 3-cycle glitch on A is rejected; a 4-cycle pulse passes (+1 then -1)
        s0 = step_cnt;
        @(posedge clk); #1; a = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk); #1; a = 1'b0;
        repeat (20) @(posedge clk); #1;
        chk("t3_glitch_steps", 32'(step_cnt - s0), 32'd0);
        chk("t3_glitch_count", 32'(count), 32'h0000FFF8);
        chk("t3_glitch_errs", 32'(err_cnt), 32'd0);
        set_ab(2'b01, 4);
        set_ab(2'b00, 25);
        repeat (10) @(posedge clk); #1;
        chk("t3_pulse4_steps", 32'(step_cnt - s0), 32'd2);
        chk("t3_pulse4_count", 32'(count), 32'h0000FFF8);

        // Latency: step appears on the 7th edge after the first sampling edge
        @(posedge clk); #1; a = 1'b1; model_move(2'b01);
        repeat (6) @(posedge clk); #1;
        chk("lat_step_early", 32'(step), 32'h0);
        @(posedge clk); #1;
        chk("lat_step_on_time", 32'(step), 32'h1);
        set_ab(2'b00, 25);

        // 4: A and B together -> err, then A low -> S11->S10 is a CW step
        set_ab(2'b11, 25);
        repeat (5) @(posedge clk); #1;
        chk("t4_err_count", 32'(count), 32'h0000FFF8);
        chk("t4_errs", 32'(err_cnt), 32'd1);
        set_ab(2'b10, 25);
        set_ab(2'b00, 25);
        repeat (5) @(posedge clk); #1;
        chk("t4_count", 32'(count), 32'h0000FFFA);

        // 5: clear, underflow, wrap at half range, clear on a step cycle
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        model_count = 16'h0;
        chk("t5_clr", 32'(count), 32'h0);
        set_ab(2'b10, 25);
        repeat (5) @(posedge clk); #1;
        chk("t5_underflow", 32'(count), 32'h0000FFFF);
        chk("t5_underflow8", 32'(count8), 32'h000000FF);
        set_ab(2'b00, 25);
        for (int k = 1; k <= 127; k++) set_ab(cw_seq[k % 4], 8);
        repeat (10) @(posedge clk); #1;
        chk("t5_7f", 32'(count), 32'h0000007F);
        chk("t5_7f_w8", 32'(count8), 32'h0000007F);
        set_ab(2'b00, 10);
        repeat (5) @(posedge clk); #1;
        chk("t5_80", 32'(count), 32'h00000080);
        chk("t5_wrap_w8", 32'(count8), 32'h00000080);
        @(posedge clk); #1; a = 1'b1;
        model_move(2'b01);
        model_count = 16'h0;
        sb[sb.size() - 1].count = 16'h0;
        repeat (6) @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("t5_clr_on_step", 32'(count), 32'h0);
        chk("t5_clr_on_step_dir", 32'(dir), 32'h0);

        // 6: reset mid-cycle, then the held level only initialises the state
        set_ab(2'b11, 25);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_count", 32'(count), 32'h0);
        chk("t6_rst_dir", 32'(dir), 32'h0);
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);
        model_count = 16'h0; model_dir = 1'b0; model_ab = 2'b11;
        s0 = step_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (30) @(posedge clk); #1;
        chk("t6_init_no_step", 32'(step_cnt - s0), 32'd0);
        chk("t6_init_count", 32'(count), 32'h0);
        set_ab(2'b10, 25);
        set_ab(2'b00, 25);
        set_ab(2'b01, 25);
        set_ab(2'b11, 25);
        repeat (10) @(posedge clk); #1;
        chk("t6_count", 32'(count), 32'd4);
        chk("t6_errs", 32'(err_cnt), 32'd1);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
